// File: rtl/perceptron_pkg.sv
// Shared types and constants for the serial output perceptron: FSM state encoding,
// accumulator width derivation and the power-on weight table.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Three guard bits cover N_IN <= 8 full-scale products without wrap.
    function automatic int unsigned sum_width(input int unsigned w_w);
        return w_w + 3;
    endfunction

    // Index 0 is the rightmost entry.
    localparam logic [7:0][7:0] DEFAULT_WEIGHTS = {
        8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4
    };

    function automatic logic [7:0] default_weight(input int unsigned i);
        return (i < 8) ? DEFAULT_WEIGHTS[i] : 8'd0;
    endfunction

endpackage

// File: rtl/perceptron_output_seq_if.sv
// Vector-in / result-out handshake bundle for perceptron_output_seq.
interface perceptron_output_seq_if #(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned SUM_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  hidden;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] sum;
    logic             fire;

    modport master (
        output in_valid, hidden, out_ready,
        input  in_ready, out_valid, sum, fire
    );

    modport slave (
        input  in_valid, hidden, out_ready,
        output in_ready, out_valid, sum, fire
    );
endinterface

// File: rtl/weight_regfile.sv
// N_IN x W_W weight store: one synchronous write port, combinational read, resets to
// the package default table.
module weight_regfile
    import perceptron_pkg::*;
#(
    parameter int unsigned N_IN  = 8,
    parameter int unsigned W_W   = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [W_W-1:0]   wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [W_W-1:0]   rd_data
);
    logic [W_W-1:0] mem [N_IN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                mem[i] <= W_W'(default_weight(i));
            end
        end else if (wr_en && (32'(wr_addr) < N_IN)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/perceptron_output_seq.sv
// Bit-serial weighted sum of a hidden vector with threshold fire flag.
// Define PERCEPTRON_WEIGHT_WR_EN to enable the runtime weight write path.
module perceptron_output_seq
    import perceptron_pkg::*;
#(
    parameter int unsigned                N_IN   = 8,
    parameter int unsigned                W_W    = 8,
    parameter logic [sum_width(W_W)-1:0]  THRESH = 11'd10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    perceptron_output_seq_if.slave io,
    input  logic                   wr_en,
    input  logic [2:0]             wr_addr,
    input  logic [W_W-1:0]         wr_data
);
    localparam int unsigned SUM_W = sum_width(W_W);
    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_t           state, state_next;
    logic [N_IN-1:0]  sreg;
    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] acc, acc_next, sum_q;
    logic             fire_q;
    logic [W_W-1:0]   weight;
    logic             accept, last;

    assign accept   = (state == IDLE) && io.in_valid;
    assign last     = (state == ACCUM) && (32'(idx) == N_IN - 1);
    assign acc_next = acc + (sreg[0] ? SUM_W'(weight) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (io.in_valid)  state_next = ACCUM;
            ACCUM:   if (last)         state_next = DONE;
            DONE:    if (io.out_ready) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state == IDLE);
        io.out_valid = (state == DONE);
        io.sum       = sum_q;
        io.fire      = fire_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg   <= '0;
            idx    <= '0;
            acc    <= '0;
            sum_q  <= '0;
            fire_q <= 1'b0;
        end else if (accept) begin
            sreg <= io.hidden;
            idx  <= '0;
            acc  <= '0;
        end else if (state == ACCUM) begin
            sreg <= sreg >> 1;
            idx  <= idx + 1'b1;
            acc  <= acc_next;
            if (last) begin
                sum_q  <= acc_next;
                fire_q <= (acc_next >= THRESH);
            end
        end
    end

`ifdef PERCEPTRON_WEIGHT_WR_EN
    logic           pend_vld;
    logic [2:0]     pend_addr;
    logic [W_W-1:0] pend_data;
    logic           rf_wr_en;
    logic [2:0]     rf_addr;
    logic [W_W-1:0] rf_data;

    // A write coinciding with acceptance is parked and committed on the DONE handshake,
    // so the vector in flight keeps reading the pre-write weights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else if (accept && wr_en) begin
            pend_vld  <= 1'b1;
            pend_addr <= wr_addr;
            pend_data <= wr_data;
        end else if ((state == DONE) && io.out_ready) begin
            pend_vld  <= 1'b0;
        end
    end

    always_comb begin
        rf_wr_en = 1'b0;
        rf_addr  = wr_addr;
        rf_data  = wr_data;
        if ((state == IDLE) && wr_en && !io.in_valid) begin
            rf_wr_en = 1'b1;
        end else if ((state == DONE) && io.out_ready && pend_vld) begin
            rf_wr_en = 1'b1;
            rf_addr  = pend_addr;
            rf_data  = pend_data;
        end
    end

    weight_regfile #(
        .N_IN  (N_IN),
        .W_W   (W_W),
        .IDX_W (IDX_W)
    ) u_weight_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (rf_wr_en),
        .wr_addr (rf_addr),
        .wr_data (rf_data),
        .rd_addr (idx),
        .rd_data (weight)
    );
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        weight = W_W'(default_weight(32'(idx)));
    end
`endif
endmodule
